// File: rtl/apb_mbox_slv.sv
// APB completer exposing a 32-bit mailbox FIFO (DATA/STATUS/CTRL/INTCLR) with a
// registered read path and a level interrupt on threshold, overflow or underflow.
`timescale 1ns/1ps
module apb_mbox_slv #(
    parameter int DEPTH = 16,
    parameter int AW    = 12
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-1:0] paddr,
    input  logic [31:0]   pwdata,
    output logic [31:0]   prdata,
    output logic          mbox_int
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_INTCLR = 2'd3;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          ovf, udf, int_en;
    logic          ovf_nxt, udf_nxt, int_en_nxt, int_nxt;
    logic [7:0]    thr, thr_nxt;
    logic [7:0]    count_ext, count_nxt_ext;
    logic          setup, access, addr_ok, empty, full, push;
    logic [1:0]    reg_sel;
    logic [31:0]   rd_mux;
    logic          unused_addr_lsb;

    assign setup           = psel & ~penable;
    assign access          = psel & penable;
    assign addr_ok         = (paddr[AW-1:4] == '0);
    assign reg_sel         = paddr[3:2];
    assign empty           = (count == '0);
    assign full            = (count == CW'(DEPTH));
    assign count_ext       = 8'(count);
    assign count_nxt_ext   = 8'(count_nxt);
    assign unused_addr_lsb = ^paddr[1:0];

    always_comb begin
        rd_mux = '0;
        if (addr_ok) begin
            case (reg_sel)
                A_DATA:   rd_mux = empty ? '0 : mem[rd_ptr];
                A_STATUS: rd_mux = {16'h0, count_ext, 4'h0, udf, ovf, full, empty};
                A_CTRL:   rd_mux = {16'h0, thr, 7'h0, int_en};
                default:  rd_mux = '0;
            endcase
        end
    end

    // All FIFO/flag updates happen on the access cycle of a decoded transfer.
    always_comb begin
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;
        count_nxt  = count;
        ovf_nxt    = ovf;
        udf_nxt    = udf;
        int_en_nxt = int_en;
        thr_nxt    = thr;
        push       = 1'b0;
        if (access && addr_ok) begin
            if (pwrite) begin
                case (reg_sel)
                    A_DATA: begin
                        if (full) begin
                            ovf_nxt = 1'b1;
                        end else begin
                            push       = 1'b1;
                            wr_ptr_nxt = wr_ptr + 1'b1;
                            count_nxt  = count + 1'b1;
                        end
                    end
                    A_CTRL: begin
                        int_en_nxt = pwdata[0];
                        thr_nxt    = pwdata[15:8];
                        if (pwdata[31]) begin
                            rd_ptr_nxt = '0;
                            wr_ptr_nxt = '0;
                            count_nxt  = '0;
                        end
                    end
                    A_INTCLR: begin
                        if (pwdata[2]) ovf_nxt = 1'b0;
                        if (pwdata[3]) udf_nxt = 1'b0;
                    end
                    default: ;
                endcase
            end else if (reg_sel == A_DATA) begin
                if (empty) begin
                    udf_nxt = 1'b1;
                end else begin
                    rd_ptr_nxt = rd_ptr + 1'b1;
                    count_nxt  = count - 1'b1;
                end
            end
        end
    end

    // Interrupt is judged on the state this cycle is about to commit.
    assign int_nxt = int_en_nxt &
                     (((thr_nxt != 8'h0) && (count_nxt_ext >= thr_nxt)) | ovf_nxt | udf_nxt);

    always_ff @(posedge pclk) begin
        if (preset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
            int_en   <= 1'b0;
            thr      <= 8'h0;
            prdata   <= '0;
            mbox_int <= 1'b0;
        end else begin
            rd_ptr   <= rd_ptr_nxt;
            wr_ptr   <= wr_ptr_nxt;
            count    <= count_nxt;
            ovf      <= ovf_nxt;
            udf      <= udf_nxt;
            int_en   <= int_en_nxt;
            thr      <= thr_nxt;
            prdata   <= (setup && !pwrite) ? rd_mux : '0;
            mbox_int <= int_nxt;
        end
    end

    always_ff @(posedge pclk) begin
        if (push && !preset) mem[wr_ptr] <= pwdata;
    end
endmodule

// File: tb/tb_apb_mbox_slv.sv
// Bench for apb_mbox_slv: register-level vector table plus hand-written fill,
// wrap, overflow, reset and flush sequences; DATA reads checked against a FIFO model.
`timescale 1ns/1ps
module tb_apb_mbox_slv;
    localparam int DEPTH = 16;
    localparam int AW    = 12;

    localparam logic [11:0] R_DATA   = 12'h000;
    localparam logic [11:0] R_STATUS = 12'h004;
    localparam logic [11:0] R_CTRL   = 12'h008;
    localparam logic [11:0] R_INTCLR = 12'h00C;
    localparam logic [11:0] R_BAD    = 12'h010;

    logic          pclk = 1'b0;
    logic          preset;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata;
    logic [31:0]   prdata;
    logic          mbox_int;

    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] sb[$];

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        bit          exp_int;
    } vec_t;

    vec_t vecs[20];

    apb_mbox_slv #(.DEPTH(DEPTH), .AW(AW)) dut (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .mbox_int(mbox_int)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // One setup+access transfer; returns with the bus idle one tick after the access edge.
    task automatic xfer(input bit w, input logic [11:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input string name);
        logic [31:0] got;
        logic [31:0] exp;
        bit          is_data;
        is_data = (a[11:4] == 8'h0) && (a[3:2] == 2'd0);
        exp     = exp_rd;
        if (w) begin
            if (is_data && sb.size() < DEPTH) sb.push_back(d);
            if (a == R_CTRL && d[31]) sb.delete();
        end else if (is_data) begin
            exp = (sb.size() > 0) ? sb.pop_front() : 32'h0;
        end
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        got = prdata;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        if (!w) check(name, got, exp);
    endtask

    initial begin
        vecs = '{
            '{0, R_STATUS, 32'h0,          32'h0000_0001, 0},
            '{0, R_DATA,   32'h0,          32'h0,         0},
            '{0, R_STATUS, 32'h0,          32'h0000_0009, 0},
            '{1, R_INTCLR, 32'h0000_0008,  32'h0,         0},
            '{0, R_STATUS, 32'h0,          32'h0000_0001, 0},
            '{0, R_INTCLR, 32'h0,          32'h0,         0},
            '{1, R_CTRL,   32'h0000_0301,  32'h0,         0},
            '{0, R_CTRL,   32'h0,          32'h0000_0301, 0},
            '{1, R_BAD,    32'h0000_0077,  32'h0,         0},
            '{0, R_STATUS, 32'h0,          32'h0000_0001, 0},
            '{0, R_BAD,    32'h0,          32'h0,         0},
            '{1, R_DATA,   32'h0000_00A1,  32'h0,         0},
            '{1, R_DATA,   32'h0000_00A2,  32'h0,         0},
            '{1, R_DATA,   32'h0000_00A3,  32'h0,         1},
            '{0, R_STATUS, 32'h0,          32'h0000_0300, 1},
            '{0, R_DATA,   32'h0,          32'h0,         0},
            '{0, R_DATA,   32'h0,          32'h0,         0},
            '{0, R_DATA,   32'h0,          32'h0,         0},
            '{1, R_CTRL,   32'h0,          32'h0,         0},
            '{0, R_CTRL,   32'h0,          32'h0,         0}
        };

        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;

        // Dirty the state, then reset during a DATA write access.
        xfer(1, R_CTRL, 32'h0000_0101, 0, "ctrl_pre");
        xfer(1, R_DATA, 32'h0000_0011, 0, "push_pre");
        check("int_pre_reset", {31'h0, mbox_int}, 32'h1);
        preset = 1'b1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = R_DATA; pwdata = 32'h55;
        @(posedge pclk); #1 penable = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        sb.delete();
        check("rst_prdata", prdata, 32'h0);
        check("rst_int", {31'h0, mbox_int}, 32'h0);

        for (int i = 0; i < 20; i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp_rd, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_int", i), {31'h0, mbox_int}, {31'h0, vecs[i].exp_int});
        end

        // Fill, overflow, then drain across the pointer wrap.
        for (int i = 0; i < DEPTH; i++) xfer(1, R_DATA, 32'h100 + i, 0, "fill");
        xfer(0, R_STATUS, 0, 32'h0000_1002, "status_full");
        xfer(1, R_DATA, 32'hDEAD_BEEF, 0, "push_ovf");
        xfer(0, R_STATUS, 0, 32'h0000_1006, "status_ovf");
        xfer(1, R_INTCLR, 32'h4, 0, "clr_ovf");
        xfer(0, R_STATUS, 0, 32'h0000_1002, "status_ovf_clr");
        for (int i = 0; i < 8; i++) xfer(0, R_DATA, 0, 0, $sformatf("pop_a%0d", i));
        for (int i = 0; i < 8; i++) xfer(1, R_DATA, 32'h200 + i, 0, "refill");
        for (int i = 0; i < 16; i++) xfer(0, R_DATA, 0, 0, $sformatf("pop_b%0d", i));
        xfer(0, R_STATUS, 0, 32'h0000_0001, "status_drained");

        // Flush keeps CTRL fields; int_en is proven alive via an underflow interrupt.
        for (int i = 0; i < 5; i++) xfer(1, R_DATA, 32'h300 + i, 0, "push5");
        xfer(0, R_STATUS, 0, 32'h0000_0500, "status_5");
        xfer(1, R_CTRL, 32'h8000_0001, 0, "flush");
        xfer(0, R_STATUS, 0, 32'h0000_0001, "status_flushed");
        xfer(0, R_CTRL, 0, 32'h0000_0001, "ctrl_after_flush");
        check("int_after_flush", {31'h0, mbox_int}, 32'h0);
        xfer(0, R_DATA, 0, 0, "udf_read");
        check("int_udf", {31'h0, mbox_int}, 32'h1);
        xfer(0, R_STATUS, 0, 32'h0000_0009, "status_udf");
        xfer(1, R_INTCLR, 32'h8, 0, "clr_udf");
        check("int_udf_clr", {31'h0, mbox_int}, 32'h0);
        xfer(0, R_BAD, 0, 0, "bad_addr");
        xfer(1, R_DATA, 32'h0000_CAFE, 0, "b2b_push");
        xfer(0, R_DATA, 0, 0, "b2b_pop");
        xfer(0, R_STATUS, 0, 32'h0000_0001, "status_end");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
